// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, an optional two-entry skid
// buffer, a synchronous flush and a saturating backpressure counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W    = 160,
    parameter int unsigned SKID_EN   = 1,
    parameter int unsigned FLUSH_CLR = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // State encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;
    logic              ld_main_in;
    logic              ld_main_skid;
    logic              ld_skid;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath load enables; flush overrides everything
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d    = ST_FULL;
                    ld_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d = ST_SKID;
                    ld_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_d      = ST_FULL;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d      = ST_EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // Outputs decoded from the state register; only the no-skid ready looks at out_ready
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        occupancy = 2'(state_q);
        if (SKID_EN != 0) begin
            in_ready = (state_q != ST_SKID);
        end else begin
            in_ready = (state_q == ST_EMPTY) | out_ready;
        end
    end

    // Payload registers; main always holds the oldest entry
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if (FLUSH_CLR != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            if (ld_main_in) begin
                main_q <= in_data;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= in_data;
            end
        end
    end

    // Saturating count of stalled-output cycles; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios on three configurations plus a
// randomized run against a queue model of the skid configuration.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // A: skid, clearing flush
    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data, a_cnt;
    logic [1:0]  a_occ;
    // B: no skid, flush keeps data
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_data, b_cnt;
    logic [1:0]  b_occ;
    // C: narrow stall counter
    logic        c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [7:0]  c_in_data, c_out_data;
    logic [3:0]  c_cnt;
    logic [1:0]  c_occ;

    pipe_stage_reg #(.DATA_W(16), .SKID_EN(1), .FLUSH_CLR(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(a_out_ready), .occupancy(a_occ), .stall_cnt(a_cnt));

    pipe_stage_reg #(.DATA_W(16), .SKID_EN(0), .FLUSH_CLR(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(b_out_ready), .occupancy(b_occ), .stall_cnt(b_cnt));

    pipe_stage_reg #(.DATA_W(8), .SKID_EN(1), .FLUSH_CLR(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(c_rst), .flush(c_flush), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
        .out_ready(c_out_ready), .occupancy(c_occ), .stall_cnt(c_cnt));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1; c_rst = 1;
        a_in_valid = 1; a_in_data = 16'h00A5;
        step(); step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", a_out_data); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", a_cnt); end
        a_rst = 0; b_rst = 0; c_rst = 0;
        a_in_valid = 0;
        step();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_streaming();
        a_out_ready = 1; a_in_valid = 1;
        for (int i = 1; i <= 10; i++) begin
            a_in_data = 16'(i);
            step();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 16'(i) || a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d got valid=%b data=%h ready=%b exp 1/%h/1", i, a_out_valid, a_out_data, a_in_ready, 16'(i));
            end
        end
        a_in_valid = 0;
        step();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got=%0d exp=0", a_occ); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h11;
        step();
        a_in_data = 16'h22;
        step();
        checks++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got occ=%0d ready=%b exp 2/0", a_occ, a_in_ready); end
        a_in_data = 16'h33;
        step(); step();
        checks++; if (a_occ !== 2'd2 || a_out_data !== 16'h11) begin errors++; $display("FAIL bp_hold got occ=%0d data=%h exp 2/11", a_occ, a_out_data); end
        a_out_ready = 1;
        step();
        checks++; if (a_out_data !== 16'h22 || a_occ !== 2'd1) begin errors++; $display("FAIL bp_second got data=%h occ=%0d exp 22/1", a_out_data, a_occ); end
        step();
        checks++; if (a_out_data !== 16'h33 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got data=%h valid=%b exp 33/1", a_out_data, a_out_valid); end
        a_in_valid = 0;
        step();
        checks++; if (a_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=3", a_cnt); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_flush();
        a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h44;
        step();
        a_in_data = 16'h55;
        step();
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL flush_setup_occ got=%0d exp=2", a_occ); end
        a_flush = 1; a_in_data = 16'h66;
        step();
        a_flush = 0; a_in_valid = 0;
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 16'h0) begin
            errors++; $display("FAIL flush_clear got valid=%b occ=%0d data=%h exp 0/0/0", a_out_valid, a_occ, a_out_data); end
        checks++; if (a_cnt !== 16'd5) begin errors++; $display("FAIL flush_keeps_cnt got=%0d exp=5", a_cnt); end
        a_out_ready = 1;
        step(); step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_66 got valid=%b data=%h exp valid 0", a_out_valid, a_out_data); end
        // flush together with out_fire and an offered in_fire
        a_in_valid = 1; a_in_data = 16'h99;
        step();
        a_flush = 1; a_in_data = 16'hAA;
        step();
        a_flush = 0; a_in_valid = 0;
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin errors++; $display("FAIL flush_with_fire got valid=%b occ=%0d exp 0/0", a_out_valid, a_occ); end
    endtask

    task automatic test_noskid();
        b_out_ready = 0; b_in_valid = 1; b_in_data = 16'h77;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_empty_ready got=%b exp=1", b_in_ready); end
        step();
        b_in_data = 16'h99;
        #1;
        checks++; if (b_in_ready !== 1'b0 || b_out_data !== 16'h77) begin errors++; $display("FAIL noskid_stall got ready=%b data=%h exp 0/77", b_in_ready, b_out_data); end
        step();
        checks++; if (b_out_data !== 16'h77 || b_occ !== 2'd1) begin errors++; $display("FAIL noskid_hold got data=%h occ=%0d exp 77/1", b_out_data, b_occ); end
        b_out_ready = 1; b_in_data = 16'h88;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_pass_ready got=%b exp=1", b_in_ready); end
        step();
        checks++; if (b_out_data !== 16'h88 || b_out_valid !== 1'b1) begin errors++; $display("FAIL noskid_load got data=%h valid=%b exp 88/1", b_out_data, b_out_valid); end
        b_in_valid = 0; b_out_ready = 0; b_flush = 1;
        step();
        b_flush = 0;
        checks++; if (b_out_data !== 16'h88 || b_out_valid !== 1'b0 || b_occ !== 2'd0) begin
            errors++; $display("FAIL noskid_flush got data=%h valid=%b occ=%0d exp 88/0/0", b_out_data, b_out_valid, b_occ); end
    endtask

    task automatic test_saturation();
        c_out_ready = 0; c_in_valid = 1; c_in_data = 8'h5C;
        step();
        c_in_valid = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (c_cnt !== 4'((i > 15) ? 15 : i)) begin
                errors++; $display("FAIL sat_cycle_%0d got=%0d exp=%0d", i, c_cnt, (i > 15) ? 15 : i);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        int          cnt_exp;
        bit          ofire, ifire;
        a_rst = 1; a_flush = 0; a_in_valid = 0; a_out_ready = 0;
        step();
        a_rst = 0;
        cnt_exp = 0;
        for (int n = 0; n < 400; n++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = 16'($urandom);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 19) == 0);
            checks++;
            if (a_in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rand_in_ready_%0d got=%b exp=%b", n, a_in_ready, q.size() < 2);
            end
            if (q.size() > 0 && !a_out_ready && cnt_exp < 65535) cnt_exp++;
            ofire = (q.size() > 0) && a_out_ready;
            ifire = a_in_valid && (q.size() < 2);
            if (a_flush) begin
                q.delete();
            end else begin
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back(a_in_data);
            end
            step();
            checks++;
            if (a_out_valid !== (q.size() > 0) || a_occ !== 2'(q.size()) || a_cnt !== 16'(cnt_exp)
                || (q.size() > 0 && a_out_data !== q[0])) begin
                errors++;
                $display("FAIL rand_out_%0d got valid=%b occ=%0d data=%h cnt=%0d exp occ=%0d data=%h cnt=%0d",
                         n, a_out_valid, a_occ, a_out_data, a_cnt, q.size(), (q.size() > 0) ? q[0] : 16'h0, cnt_exp);
            end
        end
        a_flush = 0; a_in_valid = 0;
    endtask

    initial begin
        a_rst = 1; a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_rst = 1; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        c_rst = 1; c_flush = 0; c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_noskid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register; next generation of the fixed-field stage latches between IF/ID/EX/MEM/WB.
- Replaces ad-hoc stall vectors with a valid/ready handshake, an optional 2-entry skid buffer and a synchronous flush.
- Carries one opaque bundle of DATA_W bits per transfer, plus a saturating backpressure counter for performance debug.
- Instantiated once per pipe boundary; the stage bundles are concatenated by the instantiating level.

Parameters:
- DATA_W, 160: payload width in bits (≥1).
- SKID_EN, 1: 1 = two-entry skid buffer with fully registered in_ready; 0 = single register with combinational ready pass-through.
- FLUSH_CLR, 1: 1 = flush and reset zero the payload registers; 0 = flush clears valid bits only.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous kill of all held entries (exception/branch redirect).
- in_valid  in  1  upstream holds a valid payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  DATA_W  payload to downstream.
- out_ready  in  1  downstream accepts this cycle.
- occupancy  out  2  entries held: 0, 1 or 2 (2 only when SKID_EN=1).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
Handshakes:
- Accept (in_fire) = in_valid & in_ready.
- Deliver (out_fire) = out_valid & out_ready.
- in_data is captured only on in_fire.
- out_data is stable while out_valid=1 and out_ready=0.

Priority: rst > flush > normal operation.

rst (sync):
- out_valid=0, occupancy=0, stall_cnt=0.
- Skid entry invalid; in_ready=1 from the next cycle.
- out_data=0 and skid data=0 when FLUSH_CLR=1.
- No combinational path from rst to outputs.

flush:
- Next cycle: out_valid=0, skid entry invalid, occupancy=0.
- Data registers zeroed when FLUSH_CLR=1, otherwise held.
- Any in_fire in the same cycle is discarded.
- stall_cnt is not cleared.

SKID_EN=1 states (main = out register, skid = overflow register):
- in_ready = ~skid_valid, registered.
- EMPTY (occupancy 0):
  - in_fire → FULL, main←in_data.
- FULL (occupancy 1):
  - in_fire & out_fire → FULL, main←in_data.
  - in_fire & ~out_fire → SKID, skid←in_data.
  - out_fire only → EMPTY.
  - Neither → hold.
- SKID (occupancy 2, in_ready=0):
  - out_fire → FULL, main←skid.
  - Else hold.
- Order is preserved: main always holds the oldest entry.
- Zero bubbles: sustained in_valid=out_ready=1 delivers one payload per cycle.
- Latency is 1 cycle from in_fire to out_valid.

SKID_EN=0:
- in_ready = ~out_valid | out_ready, combinational from out_ready.
- in_fire loads main and sets out_valid=1.
- out_fire without in_fire clears out_valid.
- occupancy ∈ {0,1}.

stall_cnt:
- +1 each cycle with out_valid & ~out_ready.
- Holds at 2^CNT_W−1 (no wrap).
- Cleared only by rst.

Boundary conditions:
- in_valid while in SKID: no accept; upstream must hold.
- flush and out_fire in the same cycle: the delivered payload counts as delivered downstream; the stage still empties.
- rst asserted mid-transfer: every entry is dropped; there is no partial state.
- in_valid=0 never changes held data.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_data=0xA5 → out_valid=0, out_data=0, occupancy=0, stall_cnt=0; in_ready=1 the cycle after release.
- Streaming (SKID_EN=1): in_valid=out_ready=1, in_data=1,2,3…10 → out_data=1..10 on consecutive cycles starting 1 cycle after the first accept; no gaps; in_ready stays 1.
- Backpressure: out_ready=0, push 0x11 then 0x22 → occupancy=2, in_ready=0, 0x33 held upstream. Raise out_ready → out order 0x11, 0x22, 0x33; stall_cnt equals the low-ready cycles while out_valid=1.
- Flush: occupancy=2 with payloads 0x44, 0x55; pulse flush with in_valid=1, in_data=0x66 → next cycle out_valid=0, occupancy=0, out_data=0 (FLUSH_CLR=1); 0x66 never appears.
- SKID_EN=0, FLUSH_CLR=0: hold out_ready=0 with entry 0x77 → in_ready=0. Pulse out_ready=1 with in_valid=1, in_data=0x88 → 0x88 appears next cycle. A flush leaves out_data=0x88 with out_valid=0.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.
